// File: rtl/fp_align_ctrl_pkg.sv
// fp_align_ctrl_pkg: shared FP32 field widths, limits and FSM state encoding
package fp_align_ctrl_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 27;
  localparam int MAX_SHIFT = 27;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
  typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;
endpackage

// File: rtl/fp_align_ctrl_cmp8.sv
// fp_align_ctrl_cmp8: 8-bit unsigned magnitude comparator
module fp_align_ctrl_cmp8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);
  always_comb begin
    gt = a > b;
    lt = a < b;
    eq = a == b;
  end
endmodule

// File: rtl/fp_align_ctrl.sv
// fp_align_ctrl: orders two FP32 operands by magnitude and aligns the smaller mantissa with sticky
module fp_align_ctrl
  import fp_align_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       a_bits,
  input  logic [31:0]       b_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              big_sign,
  output logic              small_sign,
  output logic [EXP_W-1:0]  big_exp,
  output logic [MANT_W-1:0] big_mant,
  output logic [MANT_W-1:0] small_mant,
  output logic              swap,
  output logic              eff_sub,
  output logic              special
);
  state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [4:0] cnt_q, cnt_d;
  logic big_sign_q, big_sign_d, small_sign_q, small_sign_d;
  logic [EXP_W-1:0] big_exp_q, big_exp_d;
  logic [MANT_W-1:0] big_mant_q, big_mant_d, small_mant_q, small_mant_d;
  logic swap_q, swap_d, eff_sub_q, eff_sub_d, special_q, special_d;
  logic [EXP_W-1:0] ea, eb, bg_e, sm_e, diff;
  logic gt, lt, eq, swp, spec;
  logic [31:0] bg, sm;
  logic [4:0] cnt_c;
  fp_align_ctrl_cmp8 u_cmp (.a(ea), .b(eb), .gt(gt), .lt(lt), .eq(eq));
  always_comb begin
    ea = (a_q[30:23] == '0) ? 8'd1 : a_q[30:23];
    eb = (b_q[30:23] == '0) ? 8'd1 : b_q[30:23];
    swp = ~gt & (lt | (eq & (b_q[22:0] > a_q[22:0])));
    bg = swp ? b_q : a_q;
    sm = swp ? a_q : b_q;
    bg_e = swp ? eb : ea;
    sm_e = swp ? ea : eb;
    diff = bg_e - sm_e;
    spec = (a_q[30:23] == EXP_SPECIAL) | (b_q[30:23] == EXP_SPECIAL);
    cnt_c = spec ? 5'd0 : (diff > 8'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : diff[4:0];
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    big_sign_d = big_sign_q;
    small_sign_d = small_sign_q;
    big_exp_d = big_exp_q;
    big_mant_d = big_mant_q;
    small_mant_d = small_mant_q;
    swap_d = swap_q;
    eff_sub_d = eff_sub_q;
    special_d = special_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a_bits;
        b_d = b_bits;
        state_d = COMPARE;
      end
      COMPARE: begin
        swap_d = swp;
        big_sign_d = bg[31];
        small_sign_d = sm[31];
        eff_sub_d = bg[31] ^ sm[31];
        big_exp_d = bg_e;
        big_mant_d = {|bg[30:23], bg[22:0], 3'b000};
        small_mant_d = {|sm[30:23], sm[22:0], 3'b000};
        special_d = spec;
        cnt_d = cnt_c;
        state_d = (cnt_c != 0) ? SHIFT : DONE;
      end
      SHIFT: begin
        small_mant_d = {1'b0, small_mant_q[26:2], |small_mant_q[1:0]};
        cnt_d = cnt_q - 5'd1;
        state_d = (cnt_q == 5'd1) ? DONE : SHIFT;
      end
      DONE: if (out_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      big_sign_q <= 1'b0;
      small_sign_q <= 1'b0;
      big_exp_q <= '0;
      big_mant_q <= '0;
      small_mant_q <= '0;
      swap_q <= 1'b0;
      eff_sub_q <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      big_sign_q <= big_sign_d;
      small_sign_q <= small_sign_d;
      big_exp_q <= big_exp_d;
      big_mant_q <= big_mant_d;
      small_mant_q <= small_mant_d;
      swap_q <= swap_d;
      eff_sub_q <= eff_sub_d;
      special_q <= special_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign big_sign = big_sign_q;
  assign small_sign = small_sign_q;
  assign big_exp = big_exp_q;
  assign big_mant = big_mant_q;
  assign small_mant = small_mant_q;
  assign swap = swap_q;
  assign eff_sub = eff_sub_q;
  assign special = special_q;
endmodule

// File: doc/fp_align_ctrl.md
# fp_align_ctrl

Sequential exponent-compare and mantissa-alignment controller for the single-precision adder front end. It accepts two IEEE754 operands through a valid/ready handshake and orders them by magnitude, using the 8-bit exponent comparator plus a mantissa tie-break. It then right-shifts the smaller mantissa one bit per cycle, with sticky collection, until the exponents match. Its outputs feed the add/subtract and normalise stages.

## Interface
- MAX_SHIFT, 27, shift-count clamp; equals the aligned mantissa width (hidden + 23 fraction + guard/round/sticky).
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a_bits, b_bits  input  32  raw IEEE754 operands.
- out_valid  output  1  aligned result valid; held until accepted.
- out_ready  input  1  downstream accepts result.
- big_sign, small_sign  output  1  signs of the larger- and smaller-magnitude operands.
- big_exp  output  8  effective exponent of the larger operand.
- big_mant, small_mant  output  27  {hidden, fraction[22:0], G, R, S}; small_mant is aligned.
- swap  output  1  high when b has the larger magnitude.
- eff_sub  output  1  big_sign XOR small_sign.
- special  output  1  either operand has exponent 0xFF (Inf/NaN); no alignment is performed.

## Operation
- Unpack each operand as follows:
  - hidden bit = (exp != 0);
  - effective exponent = (exp == 0) ? 1 : exp;
  - mantissa = {hidden, frac, 3'b000}.
- Magnitude order uses the comparator on the effective exponents. If the exponents are equal, the fractions are compared unsigned. When the operands are exactly equal, swap = 0.
- The FSM has four states: IDLE, COMPARE, SHIFT and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register both operands and go to COMPARE.
- COMPARE:
  - Register swap, big/small fields, special and eff_sub.
  - Compute cnt = min(big_exp - small_exp, MAX_SHIFT) as an 8-bit subtract; the result is never negative because the operands are ordered first.
  - If special = 1, force cnt = 0.
  - Go to SHIFT if cnt != 0, otherwise go to DONE.
- SHIFT, one step per cycle:
  - small_mant <= {1'b0, small_mant[26:1]};
  - bit 0 of the new value = old[1] | old[0], so shifted-out bits are kept in the sticky bit;
  - cnt decrements;
  - go to DONE when cnt reaches 1 on the current step.
- DONE:
  - out_valid = 1 and all outputs are stable.
  - On out_ready, return to IDLE.
  - Without out_ready, stay in DONE with outputs frozen.
- Differences of 27 or more clamp to 27 shifts. The result is 26'b0 followed by the OR of the original small mantissa.
- A zero operand (exp = 0, frac = 0) is aligned normally; its mantissa stays 0.

## Timing
- Reset values:
  - state = IDLE; in_ready = 1 in the cycle after reset releases;
  - out_valid = 0 and every data output = 0.
- Accept edge is cycle 0. COMPARE runs in cycle 1. out_valid rises in cycle 2 + n, where n = min(diff, 27).
- Latency ranges from a minimum of 2 cycles to a maximum of 29 cycles.
- in_ready is low from the cycle after acceptance until the cycle after the out_valid & out_ready handshake. There is no overlap and no back-to-back acceptance; throughput is at most one operation every n + 3 cycles.
- in_valid is ignored outside IDLE. Operands are captured only at acceptance, so input changes after that have no effect.
- out_valid & out_ready in DONE return the block to IDLE on the next edge.
- rst asserted in any state:
  - the next edge returns to IDLE and clears all outputs;
  - any in-flight operation is discarded without producing a result.

## Structure
- Shared package holds:
  - FP32 field widths (EXP_W = 8, FRAC_W = 23, MANT_W = 27);
  - EXP_SPECIAL = 8'hFF;
  - the FSM state enum (IDLE, COMPARE, SHIFT, DONE).
- Sub-module: the existing COMPARATOR_8, one instance on the effective exponents. Its gt/lt/eq outputs drive swap together with the fraction tie-break.
- The shifter is a single register with sticky OR; no barrel shifter is used.

## Test plan
- a = 0x3F800000, b = 0x3F800000:
  - out_valid in cycle 2;
  - big_mant = small_mant = 0x4000000, big_exp = 0x7F, swap = 0.
- a = 0x3F800000 (1.0), b = 0x3E800000 (0.25):
  - diff 2, out_valid in cycle 4;
  - small_mant = 0x1000000, swap = 0.
  - Swapping the inputs gives the same result with swap = 1.
- a = 0x3F800000, b = 0x2B800000 (2^-40):
  - shift count clamps to 27, out_valid in cycle 29;
  - small_mant = 0x0000001.
- a = 0x3F800000, b = 0xBFC00000 (-1.5):
  - swap = 1 via the fraction tie-break;
  - big_mant = 0x6000000, eff_sub = 1, big_sign = 1.
- Result ready with out_ready low for 5 cycles:
  - out_valid and the outputs hold steady and in_ready stays 0;
  - after out_ready pulses, in_ready returns 1 on the next cycle.
- rst pulsed in SHIFT (diff 10, 3 shifts done):
  - next cycle: IDLE, out_valid = 0, outputs all 0;
  - a new pair (a = 0x7F800000, b = 0x3F800000) gives special = 1 and out_valid in cycle 2.
